fifo_sync_ext: RTL

Parametrised single-clock FIFO for general datapath buffering; successor to the late-read sync FIFO. Adds a selectable read mode: late, with data one cycle after `re`; or first-word-fall-through (FWFT), with the head word presented whenever `ne` is high. Also adds a synchronous flush, an occupancy output, an almost-empty flag, and drop-on-overflow / ignore-on-underflow protection, so the FIFO stays consistent after an error. Storage is one dual-port block RAM with a registered read port.

---
 rtl/fifo_sync_ext_pkg.sv | 9 +
 rtl/fifo_sync_ext_ram_blk_dp.sv | 24 ++
 rtl/fifo_sync_ext.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_sync_ext_pkg.sv
// Shared FIFO definitions: read-mode encodings used by every FIFO variant.
package fifo_defs;

    typedef enum logic {
        FIFO_MODE_LATE = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

endpackage

// File: rtl/fifo_sync_ext_ram_blk_dp.sv
// Simple dual-port block RAM: one write port, one registered read port.
module ram_blk_dp #(
    parameter int unsigned ADDRWIDTH = 5,
    parameter int unsigned DATAWIDTH = 18
) (
    input  logic                 clk,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic [ADDRWIDTH-1:0] wr_addr,
    input  logic                 we,
    input  logic [ADDRWIDTH-1:0] rd_addr,
    output logic [DATAWIDTH-1:0] rd_data
);

    logic [DATAWIDTH-1:0] mem [2**ADDRWIDTH];

    // Same-address read during a write returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_sync_ext.sv
// Single-clock FIFO with late or first-word-fall-through read, flush,
// occupancy/almost flags and drop-on-overflow / ignore-on-underflow.
module fifo_sync_ext
    import fifo_defs::*;
#(
    parameter int unsigned ADDRWIDTH = 5,
    parameter int unsigned DATAWIDTH = 18,
    parameter int unsigned SLOP      = 4,
    parameter int unsigned AE_LEVEL  = 2,
    parameter fifo_mode_e  MODE      = FIFO_MODE_FWFT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 we,
    output logic                 ns_full,
    output logic                 full,
    output logic                 ovf,
    output logic [DATAWIDTH-1:0] rd_data,
    input  logic                 re,
    output logic                 ne,
    output logic                 aempty,
    output logic                 unf,
    output logic [ADDRWIDTH:0]   level
);

    localparam int unsigned LW    = ADDRWIDTH + 1;
    localparam int unsigned DEPTH = 2**ADDRWIDTH;
    localparam bit          FWFT  = (MODE == FIFO_MODE_FWFT);

    logic [ADDRWIDTH-1:0] wr_addr;
    logic [ADDRWIDTH-1:0] rd_addr;
    logic [ADDRWIDTH-1:0] rd_addr_nx;
    logic [ADDRWIDTH-1:0] ram_rd_addr;
    logic [ADDRWIDTH:0]   level_nx;
    logic [ADDRWIDTH:0]   rd_cnt;
    logic                 wr_ok;
    logic                 pop;
    logic                 wr_d1;
    logic [DATAWIDTH-1:0] ram_q;
    logic [DATAWIDTH-1:0] fwft_q;

    always_comb begin
        wr_ok      = we && !clr && !reset && (level != LW'(DEPTH));
        pop        = re && ne && !clr && !reset;
        level_nx   = (reset || clr) ? '0 : level + LW'(wr_ok) - LW'(pop);
        rd_addr_nx = (reset || clr) ? '0 : rd_addr + ADDRWIDTH'(pop);
        ns_full    = (level_nx >= LW'(DEPTH - SLOP));
        // FWFT prefetches the upcoming head; late mode reads the word being
        // popped so it lands on rd_data one cycle after re.
        ram_rd_addr = FWFT ? rd_addr_nx : rd_addr;
    end

    ram_blk_dp #(
        .ADDRWIDTH(ADDRWIDTH),
        .DATAWIDTH(DATAWIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_data(wr_data),
        .wr_addr(wr_addr),
        .we     (wr_ok),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_q)
    );

    assign ne      = (rd_cnt != '0);
    assign rd_data = FWFT ? (ne ? ram_q : fwft_q) : ram_q;

    // rd_cnt lags level by the RAM write plus registered read (wr_d1 stage).
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_addr <= '0;
            rd_addr <= '0;
            level   <= '0;
            rd_cnt  <= '0;
            wr_d1   <= 1'b0;
            full    <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            aempty  <= 1'b1;
            fwft_q  <= '0;
        end else begin
            wr_addr <= wr_addr + ADDRWIDTH'(wr_ok);
            rd_addr <= rd_addr_nx;
            level   <= level_nx;
            rd_cnt  <= rd_cnt + LW'(wr_d1) - LW'(pop);
            wr_d1   <= wr_ok;
            full    <= ns_full;
            aempty  <= (level_nx <= LW'(AE_LEVEL));
            if (we && level == LW'(DEPTH)) begin
                ovf <= 1'b1;
            end
            if (re && !ne) begin
                unf <= 1'b1;
            end
            if (ne) begin
                fwft_q <= ram_q;
            end
        end
    end

endmodule
